frame_ram_scheduler: RTL

//  Sequences one simple dual-port frame RAM (1 write port, 1 read port, 3-cycle registered read) in the sobel path.

---
 rtl/frame_ram_sched_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/frame_ram_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/frame_ram_sched_pkg.sv
// rtl/frame_ram_sched_pkg.sv - shared constants and types for the frame RAM scheduler
package frame_ram_sched_pkg;

  // Read requester identifiers
  localparam logic RD_ID_SOBEL = 1'b0;
  localparam logic RD_ID_HOST  = 1'b1;

  // Default RAM read latency in clock edges (read address -> q)
  localparam int RD_LATENCY_DEFAULT = 3;

  // In-flight read tag carried alongside the RAM read latency
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter over eligible requests
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_eligible,
  output logic [1:0] o_gnt
);

  logic [1:0] w_cand;
  logic       r_prio;   // requester favoured when both are candidates

  assign w_cand = i_req & i_eligible;

  // Grant a lone candidate at once; on contention favour r_prio
  always_comb begin
    o_gnt = 2'b00;
    if (w_cand == 2'b11) begin
      o_gnt = r_prio ? 2'b10 : 2'b01;
    end else begin
      o_gnt = w_cand;
    end
  end

  // After any grant, priority passes to the other requester
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (|o_gnt) begin
      r_prio <= o_gnt[0];
    end
  end

endmodule

// File: rtl/frame_ram_scheduler.sv
// rtl/frame_ram_scheduler.sv - frame RAM write sequencing, read arbitration and return routing
module frame_ram_scheduler
  import frame_ram_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 20,
  parameter int FRAME_WORDS = 524288,
  parameter int RD_LATENCY  = RD_LATENCY_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sof,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_frame_done,
  output logic                  o_frame_valid,
  input  logic                  i_rd0_req,
  input  logic [ADDR_WIDTH-1:0] i_rd0_addr,
  output logic                  o_rd0_gnt,
  output logic                  o_rd0_rvalid,
  output logic [DATA_WIDTH-1:0] o_rd0_rdata,
  input  logic                  i_rd1_req,
  input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
  output logic                  o_rd1_gnt,
  output logic                  o_rd1_rvalid,
  output logic [DATA_WIDTH-1:0] o_rd1_rdata,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic [ADDR_WIDTH-1:0] o_ram_write_addr,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_read_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  logic                  r_wr_ready;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_frame_valid;
  logic                  r_frame_done;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_waddr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic [ADDR_WIDTH-1:0] r_ram_raddr;
  rd_tag_t               r_tag_pipe [RD_LATENCY];
  logic [1:0]            r_rvalid;

  logic                  w_wr_fire;
  logic [1:0]            w_req;
  logic [1:0]            w_elig;
  logic [1:0]            w_gnt;
  rd_tag_t               w_issue_tag;
  rd_tag_t               w_tail;

  assign w_wr_fire = i_wr_valid & r_wr_ready;

  // Within the first frame a read may only target words already written
  assign w_req  = {i_rd1_req, i_rd0_req};
  assign w_elig = {r_frame_valid | (i_rd1_addr < r_wr_ptr),
                   r_frame_valid | (i_rd0_addr < r_wr_ptr)};

  rr_arbiter2 u_arb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (w_req),
    .i_eligible (w_elig),
    .o_gnt      (w_gnt)
  );

  assign w_issue_tag.valid = |w_gnt;
  assign w_issue_tag.id    = w_gnt[1];
  assign w_tail            = r_tag_pipe[RD_LATENCY-1];

  // Write port: register the accepted word and advance the linear write pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ready    <= 1'b0;
      r_wr_ptr      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_waddr   <= '0;
      r_ram_data    <= '0;
    end else begin
      r_wr_ready   <= 1'b1;
      r_ram_we     <= w_wr_fire;
      r_frame_done <= 1'b0;
      if (w_wr_fire) begin
        r_ram_data <= i_wr_data;
        if (i_sof) begin
          r_ram_waddr <= '0;
          r_wr_ptr    <= ONE;
        end else begin
          r_ram_waddr <= r_wr_ptr;
          if (r_wr_ptr == LAST_ADDR) begin
            r_wr_ptr      <= '0;
            r_frame_done  <= 1'b1;
            r_frame_valid <= 1'b1;
          end else begin
            r_wr_ptr <= r_wr_ptr + ONE;
          end
        end
      end else if (i_sof) begin
        r_wr_ptr <= '0;
      end
    end
  end

  // Read issue: latch the granted address and push its tag into the latency pipe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_raddr <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_tag_pipe[i] <= '0;
      end
    end else begin
      if (w_gnt[0]) begin
        r_ram_raddr <= i_rd0_addr;
      end else if (w_gnt[1]) begin
        r_ram_raddr <= i_rd1_addr;
      end
      r_tag_pipe[0] <= w_issue_tag;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  // Return demux: flag the owner of the word arriving on ram_q this cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 2'b00;
    end else begin
      r_rvalid[0] <= w_tail.valid & (w_tail.id == RD_ID_SOBEL);
      r_rvalid[1] <= w_tail.valid & (w_tail.id == RD_ID_HOST);
    end
  end

  assign o_wr_ready       = r_wr_ready;
  assign o_frame_done     = r_frame_done;
  assign o_frame_valid    = r_frame_valid;
  assign o_rd0_gnt        = w_gnt[0];
  assign o_rd1_gnt        = w_gnt[1];
  assign o_rd0_rvalid     = r_rvalid[0];
  assign o_rd1_rvalid     = r_rvalid[1];
  assign o_rd0_rdata      = r_rvalid[0] ? i_ram_q : '0;
  assign o_rd1_rdata      = r_rvalid[1] ? i_ram_q : '0;
  assign o_ram_data       = r_ram_data;
  assign o_ram_write_addr = r_ram_waddr;
  assign o_ram_we         = r_ram_we;
  assign o_ram_read_addr  = r_ram_raddr;

endmodule
